compensation_interpolator: RTL

- Transmit-path CIC pre-compensation filter: a polyphase interpolating FIR that accepts one baseband sample and emits INTERP filtered output samples, ahead of the CIC interpolator.
- It mirrors the receive-side decimating compensation FIR.
- A single time-multiplexed signed MAC performs the arithmetic.
- Input and output use valid/ready handshakes.
- Coefficients are runtime-loadable.

---
 rtl/compensation_interpolator.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/compensation_interpolator.sv
// Polyphase interpolating CIC pre-compensation FIR: one input sample produces INTERP
// outputs, each the dot product of the delay line with one coefficient phase.
module compensation_interpolator #(
  parameter int WIDTH       = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter int INTERP      = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [WIDTH-1:0]                      data_in_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  output logic [WIDTH-1:0]                      data_out_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  input  logic                                  coeff_we_i,
  input  logic [$clog2(TAPS*INTERP)-1:0]        coeff_addr_i,
  input  logic [COEFF_WIDTH-1:0]                coeff_wdata_i,
  output logic                                  busy_o
);

  localparam int NCOEF  = TAPS * INTERP;
  localparam int AW     = $clog2(NCOEF);
  localparam int TW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW     = $clog2(INTERP);
  localparam int PROD_W = WIDTH + COEFF_WIDTH;
  localparam int ACC_W  = PROD_W + ((TAPS > 1) ? $clog2(TAPS) : 0);

  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
  localparam logic signed [COEFF_WIDTH-1:0] H0_DEFAULT = COEFF_WIDTH'(1) <<< (COEFF_WIDTH - 2);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state_q;
  logic                          in_ready_q;
  logic                          out_valid_q;
  logic                          busy_q;
  logic [WIDTH-1:0]              data_out_q;
  logic [TW-1:0]                 t_q;
  logic [PW-1:0]                 p_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [WIDTH-1:0]       x_q [TAPS];
  logic signed [COEFF_WIDTH-1:0] h_q [NCOEF];

  logic [AW-1:0]                 coeff_idx;
  logic signed [WIDTH-1:0]       x_sel;
  logic signed [COEFF_WIDTH-1:0] h_sel;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_d;
  logic signed [ACC_W-1:0]       shifted;
  logic [WIDTH-1:0]              out_d;

  // Prototype filter index for tap t of phase p is t*INTERP + p.
  assign coeff_idx = AW'(int'(t_q) * INTERP + int'(p_q));
  assign x_sel     = x_q[t_q];
  assign h_sel     = h_q[coeff_idx];
  assign prod      = PROD_W'(x_sel) * PROD_W'(h_sel);
  assign acc_d     = acc_q + ACC_W'(prod);
  assign shifted   = acc_d >>> (COEFF_WIDTH - 1);

  always_comb begin
    out_d = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      out_d = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      out_d = SAT_MIN[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      data_out_q  <= '0;
      t_q         <= '0;
      p_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) begin
        h_q[i] <= (i == 0) ? H0_DEFAULT : '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          // A write on the accepting edge lands before the first MAC cycle reads it.
          if (coeff_we_i && (int'(coeff_addr_i) < NCOEF)) begin
            h_q[coeff_addr_i] <= coeff_wdata_i;
          end
          if (in_valid_i && in_ready_q) begin
            x_q[0] <= data_in_i;
            for (int i = 1; i < TAPS; i++) begin
              x_q[i] <= x_q[i-1];
            end
            p_q        <= '0;
            t_q        <= '0;
            acc_q      <= '0;
            state_q    <= MAC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          if (t_q == TW'(TAPS - 1)) begin
            data_out_q  <= out_d;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            if (p_q == PW'(INTERP - 1)) begin
              state_q    <= IDLE;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              p_q     <= p_q + 1'b1;
              t_q     <= '0;
              acc_q   <= '0;
              state_q <= MAC;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign data_out_o  = data_out_q;
  assign busy_o      = busy_q;

endmodule
